// File: rtl/axi4l_arb2.sv
// Two-master, one-slave AXI4-Lite arbiter.
// Grants whole transactions round-robin; the loser is held stalled.
module axi4l_arb2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
  input  logic                    s0_awvalid,
  output logic                    s0_awready,
  input  logic [DATA_WIDTH-1:0]   s0_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
  input  logic                    s0_wvalid,
  output logic                    s0_wready,
  output logic [1:0]              s0_bresp,
  output logic                    s0_bvalid,
  input  logic                    s0_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_araddr,
  input  logic                    s0_arvalid,
  output logic                    s0_arready,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  output logic [1:0]              s0_rresp,
  output logic                    s0_rvalid,
  input  logic                    s0_rready,
  input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic                    s1_awvalid,
  output logic                    s1_awready,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
  input  logic                    s1_wvalid,
  output logic                    s1_wready,
  output logic [1:0]              s1_bresp,
  output logic                    s1_bvalid,
  input  logic                    s1_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_araddr,
  input  logic                    s1_arvalid,
  output logic                    s1_arready,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic [1:0]              s1_rresp,
  output logic                    s1_rvalid,
  input  logic                    s1_rready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic [1:0]              grant,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE, WADDR, WRESP, RADDR, RRESP
  } state_t;

  state_t     state, state_n;
  logic [1:0] grant_n;
  logic       last, last_n;
  logic       aw_done, aw_done_n;
  logic       w_done, w_done_n;
  logic       win, req0, req1;
  logic       in_wa, in_wr, in_ra, in_rr;
  logic       sel;

  assign sel   = grant[1];
  assign busy  = (state != IDLE);
  assign in_wa = (state == WADDR);
  assign in_wr = (state == WRESP);
  assign in_ra = (state == RADDR);
  assign in_rr = (state == RRESP);
  assign req0  = s0_awvalid | s0_arvalid;
  assign req1  = s1_awvalid | s1_arvalid;

  // slave side: granted master's channels, gated by phase
  always_comb begin
    m_awaddr  = '0;
    m_awvalid = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_araddr  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    if (in_wa) begin
      m_awaddr  = sel ? s1_awaddr : s0_awaddr;
      m_awvalid = ~aw_done &
                  (sel ? s1_awvalid : s0_awvalid);
      m_wdata   = sel ? s1_wdata : s0_wdata;
      m_wstrb   = sel ? s1_wstrb : s0_wstrb;
      m_wvalid  = ~w_done &
                  (sel ? s1_wvalid : s0_wvalid);
    end
    if (in_wr)
      m_bready = sel ? s1_bready : s0_bready;
    if (in_ra) begin
      m_araddr  = sel ? s1_araddr : s0_araddr;
      m_arvalid = sel ? s1_arvalid : s0_arvalid;
    end
    if (in_rr)
      m_rready = sel ? s1_rready : s0_rready;
  end

  logic                  awr, wr, bv, arr, rv;
  logic [1:0]            br, rr;
  logic [DATA_WIDTH-1:0] rd;

  assign awr = in_wa & ~aw_done & m_awready;
  assign wr  = in_wa & ~w_done & m_wready;
  assign bv  = in_wr & m_bvalid;
  assign br  = in_wr ? m_bresp : 2'b00;
  assign arr = in_ra & m_arready;
  assign rv  = in_rr & m_rvalid;
  assign rr  = in_rr ? m_rresp : 2'b00;
  assign rd  = in_rr ? m_rdata : '0;

  assign s0_awready = grant[0] & awr;
  assign s0_wready  = grant[0] & wr;
  assign s0_bvalid  = grant[0] & bv;
  assign s0_bresp   = grant[0] ? br : 2'b00;
  assign s0_arready = grant[0] & arr;
  assign s0_rvalid  = grant[0] & rv;
  assign s0_rresp   = grant[0] ? rr : 2'b00;
  assign s0_rdata   = grant[0] ? rd : '0;
  assign s1_awready = grant[1] & awr;
  assign s1_wready  = grant[1] & wr;
  assign s1_bvalid  = grant[1] & bv;
  assign s1_bresp   = grant[1] ? br : 2'b00;
  assign s1_arready = grant[1] & arr;
  assign s1_rvalid  = grant[1] & rv;
  assign s1_rresp   = grant[1] ? rr : 2'b00;
  assign s1_rdata   = grant[1] ? rd : '0;

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    last_n    = last;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    win       = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          win       = (req0 & req1) ? ~last : req1;
          grant_n   = win ? 2'b10 : 2'b01;
          last_n    = win;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          state_n   = (win ? s1_awvalid : s0_awvalid)
                      ? WADDR : RADDR;
        end
      end
      WADDR: begin
        aw_done_n = aw_done | (m_awvalid & m_awready);
        w_done_n  = w_done | (m_wvalid & m_wready);
        if (aw_done_n & w_done_n) begin
          state_n   = WRESP;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end
      end
      WRESP: begin
        if (m_bvalid & m_bready) begin
          state_n = IDLE;
          grant_n = 2'b00;
        end
      end
      RADDR: begin
        if (m_arvalid & m_arready)
          state_n = RRESP;
      end
      RRESP: begin
        if (m_rvalid & m_rready) begin
          state_n = IDLE;
          grant_n = 2'b00;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 2'b00;
      last    <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      last    <= last_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end
  end

endmodule

// File: tb/tb_axi4l_arb2.sv
// Randomized bench for axi4l_arb2 against a transaction-level model.
// Directed scenarios pin the model with literal expectations.
module tb_axi4l_arb2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][31:0] awaddr, wdata, araddr;
  logic [1:0][3:0]  wstrb;
  logic [1:0]       awvalid, wvalid, bready;
  logic [1:0]       arvalid, rready;
  logic [1:0]       s_awready, s_wready, s_bvalid;
  logic [1:0]       s_arready, s_rvalid;
  logic [1:0][1:0]  s_bresp, s_rresp;
  logic [1:0][31:0] s_rdata;

  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready;
  logic        m_rvalid, m_rready;
  logic [1:0]  grant;
  logic        busy;

  axi4l_arb2 dut (
    .clk(clk), .rst(rst),
    .s0_awaddr(awaddr[0]), .s0_awvalid(awvalid[0]),
    .s0_awready(s_awready[0]),
    .s0_wdata(wdata[0]), .s0_wstrb(wstrb[0]),
    .s0_wvalid(wvalid[0]), .s0_wready(s_wready[0]),
    .s0_bresp(s_bresp[0]), .s0_bvalid(s_bvalid[0]),
    .s0_bready(bready[0]),
    .s0_araddr(araddr[0]), .s0_arvalid(arvalid[0]),
    .s0_arready(s_arready[0]),
    .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]),
    .s0_rvalid(s_rvalid[0]), .s0_rready(rready[0]),
    .s1_awaddr(awaddr[1]), .s1_awvalid(awvalid[1]),
    .s1_awready(s_awready[1]),
    .s1_wdata(wdata[1]), .s1_wstrb(wstrb[1]),
    .s1_wvalid(wvalid[1]), .s1_wready(s_wready[1]),
    .s1_bresp(s_bresp[1]), .s1_bvalid(s_bvalid[1]),
    .s1_bready(bready[1]),
    .s1_araddr(araddr[1]), .s1_arvalid(arvalid[1]),
    .s1_arready(s_arready[1]),
    .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]),
    .s1_rvalid(s_rvalid[1]), .s1_rready(rready[1]),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid),
    .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant(grant), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // transaction-level model: owner (-1 idle), kind, phase
  int own    = -1;
  bit is_wr  = 0;
  bit resp   = 0;
  bit aw_got = 0;
  bit w_got  = 0;
  int prev   = 1;
  bit chk_en = 0;
  bit [1:0] ah = 0, wh = 0, arh = 0;

  task automatic chk(string nm, logic [127:0] a,
                     logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic step();
    int g, nown, w;
    bit wa, wrs, ra, rr, mi;
    bit nwr, nresp, naw, nw;
    int nprev;
    bit [1:0] req;
    logic [127:0] e, a;
    #1;
    g   = (own < 0) ? 0 : own;
    wa  = own >= 0 && is_wr && !resp;
    wrs = own >= 0 && is_wr && resp;
    ra  = own >= 0 && !is_wr && !resp;
    rr  = own >= 0 && !is_wr && resp;
    for (int i = 0; i < 2; i++) begin
      mi = (own == i);
      ah[i]  = mi & wa & !aw_got & m_awready
               & awvalid[i];
      wh[i]  = mi & wa & !w_got & m_wready
               & wvalid[i];
      arh[i] = mi & ra & m_arready & arvalid[i];
    end
    if (chk_en) begin
      e = {(wa ? awaddr[g] : 32'h0),
           wa & awvalid[g] & !aw_got,
           (wa ? wdata[g] : 32'h0),
           (wa ? wstrb[g] : 4'h0),
           wa & wvalid[g] & !w_got,
           wrs & bready[g],
           (ra ? araddr[g] : 32'h0),
           ra & arvalid[g],
           rr & rready[g]};
      a = {m_awaddr, m_awvalid, m_wdata, m_wstrb,
           m_wvalid, m_bready, m_araddr, m_arvalid,
           m_rready};
      chk("m_side", a, e);
      for (int i = 0; i < 2; i++) begin
        mi = (own == i);
        e = {mi & wa & !aw_got & m_awready,
             mi & wa & !w_got & m_wready,
             mi & wrs & m_bvalid,
             ((mi & wrs) ? m_bresp : 2'b00),
             mi & ra & m_arready,
             mi & rr & m_rvalid,
             ((mi & rr) ? m_rresp : 2'b00),
             ((mi & rr) ? m_rdata : 32'h0)};
        a = {s_awready[i], s_wready[i], s_bvalid[i],
             s_bresp[i], s_arready[i], s_rvalid[i],
             s_rresp[i], s_rdata[i]};
        chk($sformatf("s%0d_side", i), a, e);
      end
      e = {(own < 0) ? 2'b00 :
           ((own == 1) ? 2'b10 : 2'b01), own >= 0};
      chk("ctl", {grant, busy}, e);
    end
    nown = own; nwr = is_wr; nresp = resp;
    naw = aw_got; nw = w_got; nprev = prev;
    req = awvalid | arvalid;
    if (rst) begin
      nown = -1; nprev = 1; naw = 0; nw = 0;
    end else if (own < 0) begin
      if (req != 2'b00) begin
        w = (req == 2'b11) ? 1 - prev
            : (req[1] ? 1 : 0);
        nown = w; nprev = w;
        nwr = awvalid[w]; nresp = 0;
        naw = 0; nw = 0;
      end
    end else if (wa) begin
      naw = aw_got | ah[g];
      nw  = w_got | wh[g];
      if (naw && nw) begin
        nresp = 1; naw = 0; nw = 0;
      end
    end else if (wrs) begin
      if (m_bvalid && bready[g]) nown = -1;
    end else if (ra) begin
      if (arh[g]) nresp = 1;
    end else if (rr) begin
      if (m_rvalid && rready[g]) nown = -1;
    end
    @(posedge clk);
    if (rst) chk_en = 1;
    own = nown; is_wr = nwr; resp = nresp;
    aw_got = naw; w_got = nw; prev = nprev;
    @(negedge clk);
  endtask

  task automatic rand_drive();
    for (int i = 0; i < 2; i++) begin
      if (awvalid[i] && ah[i]) awvalid[i] = 0;
      if (!awvalid[i] && $urandom_range(3) == 0) begin
        awvalid[i] = 1;
        awaddr[i]  = $urandom;
      end
      if (wvalid[i] && wh[i]) wvalid[i] = 0;
      if (!wvalid[i] && $urandom_range(3) == 0) begin
        wvalid[i] = 1;
        wdata[i]  = $urandom;
        wstrb[i]  = 4'($urandom);
      end
      if (arvalid[i] && arh[i]) arvalid[i] = 0;
      if (!arvalid[i] && $urandom_range(3) == 0) begin
        arvalid[i] = 1;
        araddr[i]  = $urandom;
      end
      bready[i] = $urandom_range(3) != 0;
      rready[i] = $urandom_range(3) != 0;
    end
    m_awready = $urandom_range(2) != 0;
    m_wready  = $urandom_range(2) != 0;
    m_arready = $urandom_range(2) != 0;
    m_bvalid  = $urandom_range(2) != 0;
    m_rvalid  = $urandom_range(2) != 0;
    m_bresp   = 2'($urandom);
    m_rresp   = 2'($urandom);
    m_rdata   = $urandom;
    rst       = $urandom_range(499) == 0;
  endtask

  initial begin
    rst = 1;
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
    awvalid = '0; wvalid = '0; arvalid = '0;
    bready = '0; rready = '0;
    m_awready = 0; m_wready = 0; m_arready = 0;
    m_bvalid = 0; m_rvalid = 0; m_bresp = 0;
    m_rresp = 0; m_rdata = 0;
    @(negedge clk);
    step(); step();
    rst = 0;
    #1 chk("rst_ctl", {grant, busy}, 3'b000);

    // single write from s0
    awvalid[0] = 1; awaddr[0] = 32'h4;
    wvalid[0] = 1; wdata[0] = 32'hA5; wstrb[0] = 4'hF;
    m_awready = 1; m_wready = 1;
    m_bvalid = 1; m_bresp = 2'b00; bready[0] = 1;
    step();
    #1 chk("wr_grant", grant, 2'b01);
    chk("wr_awaddr", m_awaddr, 32'h4);
    chk("wr_wdata", m_wdata, 32'hA5);
    chk("wr_s1rdy", {s_awready[1], s_wready[1]}, 0);
    step();
    awvalid[0] = 0; wvalid[0] = 0;
    #1 chk("wr_b", {s_bvalid[0], s_bresp[0]}, 3'b100);
    step();
    #1 chk("wr_idle", {grant, busy}, 3'b000);

    // read tie after reset: s0 then s1
    rst = 1; step(); rst = 0;
    arvalid = 2'b11;
    araddr[0] = 32'h10; araddr[1] = 32'h20;
    m_arready = 1; m_rvalid = 1; rready = 2'b11;
    m_rdata = 32'h1111_1111; m_rresp = 0;
    step();
    #1 chk("tie_g0", grant, 2'b01);
    chk("tie_a0", m_araddr, 32'h10);
    step();
    arvalid[0] = 0;
    #1 chk("tie_r0", s_rdata[0], 32'h1111_1111);
    chk("tie_nr1", s_rvalid[1], 1'b0);
    step();
    #1 chk("tie_gap", grant, 2'b00);
    step();
    #1 chk("tie_g1", grant, 2'b10);
    chk("tie_a1", m_araddr, 32'h20);
    step();
    arvalid[1] = 0; m_rdata = 32'h2222_2222;
    #1 chk("tie_r1", s_rdata[1], 32'h2222_2222);
    step();

    // fairness under continuous read requests
    rst = 1; step(); rst = 0;
    arvalid = 2'b11;
    step();
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("fair%0d", k), grant,
             (k % 2 == 0) ? 2'b01 : 2'b10);
      step(); step(); step();
    end

    // B backpressure then reset in WRESP
    arvalid = 2'b00;
    rst = 1; step(); rst = 0;
    awvalid[0] = 1; wvalid[0] = 1; bready[0] = 0;
    m_awready = 1; m_wready = 1; m_bvalid = 1;
    step(); step();
    awvalid[0] = 0; wvalid[0] = 0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_hold", {s_bvalid[0], busy}, 2'b11);
      step();
    end
    rst = 1; step(); rst = 0;
    #1 chk("rst_mid", {grant, busy, m_awvalid,
           m_wvalid, m_arvalid, s_bvalid}, 0);
    arvalid = 2'b11;
    step();
    #1 chk("rst_last", grant, 2'b01);

    ah = 0; wh = 0; arh = 0;
    for (int c = 0; c < 4000; c++) begin
      rand_drive();
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
